// File: rtl/floyd_warshall_main.sv
// 8-node Floyd-Warshall accelerator: byte-wide distance matrix behind a 2-channel slave port,
// relaxed in place through its own 2-channel master port. Define FW_SKIP_INF_EN to skip j loops with d[i][k]=inf.
module floyd_warshall_main #(
  parameter int unsigned MEM_var_28859_28864 = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_port,
  input  logic [1:0]  S_oe_ram,
  input  logic [1:0]  S_we_ram,
  input  logic [23:0] S_addr_ram,
  input  logic [15:0] S_Wdata_ram,
  input  logic [7:0]  S_data_ram_size,
  input  logic [15:0] M_Rdata_ram,
  input  logic [1:0]  M_DataRdy,
  output logic        done_port,
  output logic [15:0] Sout_Rdata_ram,
  output logic [1:0]  Sout_DataRdy,
  output logic [1:0]  Mout_oe_ram,
  output logic [1:0]  Mout_we_ram,
  output logic [23:0] Mout_addr_ram,
  output logic [15:0] Mout_Wdata_ram,
  output logic [7:0]  Mout_data_ram_size
);

  localparam int unsigned CELLS = 64;
  localparam logic [11:0] BASE  = 12'(MEM_var_28859_28864);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_PAIR = 2'd1;
  localparam logic [1:0] S_RD_IJ   = 2'd2;
  localparam logic [1:0] S_UPD     = 2'd3;

  function automatic logic [7:0] init_val(input int unsigned n);
    int unsigned i, j;
    i = n / 8;
    j = n % 8;
    if (i == j) return 8'd0;
    else if (((i + j) % 3) == 0) return 8'hFF;
    else return 8'(((7 * i + 3 * j) % 16) + 1);
  endfunction

  logic [7:0]  mem_q [CELLS];
  logic [7:0]  mem_d [CELLS];
  logic [1:0]  s_rdy_q, s_rdy_d;
  logic [15:0] s_rdata_q, s_rdata_d;

  logic [1:0][11:0] s_addr_c;
  logic [1:0][5:0]  s_off_c;
  logic [1:0]       s_hit_c;
  logic             unused_c;

  assign s_addr_c   = S_addr_ram;
  assign s_off_c[0] = 6'(s_addr_c[0] - BASE);
  assign s_off_c[1] = 6'(s_addr_c[1] - BASE);
  assign s_hit_c[0] = (s_addr_c[0] >= BASE) && ((s_addr_c[0] - BASE) < 12'd64);
  assign s_hit_c[1] = (s_addr_c[1] >= BASE) && ((s_addr_c[1] - BASE) < 12'd64);
  assign unused_c   = ^S_data_ram_size;

  // Slave: reads see pre-write contents; channel 1 applied last so it wins write collisions.
  always_comb begin
    mem_d     = mem_q;
    s_rdy_d   = '0;
    s_rdata_d = '0;
    for (int c = 0; c < 2; c++) begin
      if (s_hit_c[c] && (S_oe_ram[c] || S_we_ram[c])) s_rdy_d[c] = 1'b1;
      if (s_hit_c[c] && S_oe_ram[c]) s_rdata_d[8*c +: 8] = mem_q[s_off_c[c]];
      if (s_hit_c[c] && S_we_ram[c] && !S_oe_ram[c]) mem_d[s_off_c[c]] = S_Wdata_ram[8*c +: 8];
    end
  end

  logic [1:0]  state_q, state_d;
  logic        phase_q, phase_d;
  logic [8:0]  iter_q, iter_d;
  logic [7:0]  dik_q, dik_d, dkj_q, dkj_d;
  logic        done_q, done_d;
  logic [1:0]  m_oe_q, m_oe_d, m_we_q, m_we_d;
  logic [23:0] m_addr_q, m_addr_d;
  logic [15:0] m_wdata_q, m_wdata_d;
  logic [7:0]  m_size_q, m_size_d;

  logic [8:0]  sum_c;
  logic [7:0]  cand_c;
  logic        skip_c;
  logic        skip_now_c, launch_c, adv_c;
  logic [8:0]  adv_base_c;

  assign sum_c  = {1'b0, dik_q} + {1'b0, dkj_q};
  assign cand_c = sum_c[8] ? 8'hFF : sum_c[7:0];

`ifdef FW_SKIP_INF_EN
  assign skip_c = (iter_q[2:0] == 3'd0) && (M_Rdata_ram[7:0] == 8'hFF);
`else
  assign skip_c = 1'b0;
`endif

  // Engine: phase 0 is the cycle the request first appears; phase 1 waits for its completion.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    iter_d     = iter_q;
    dik_d      = dik_q;
    dkj_d      = dkj_q;
    done_d     = 1'b0;
    m_oe_d     = m_oe_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    m_size_d   = m_size_q;
    skip_now_c = 1'b0;
    launch_c   = 1'b0;
    adv_c      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_port) begin
          state_d  = S_RD_PAIR;
          iter_d   = '0;
          launch_c = 1'b1;
        end
      end
      S_RD_PAIR: begin
        if (!phase_q) phase_d = 1'b1;
        else if (M_DataRdy == 2'b11) begin
          dik_d = M_Rdata_ram[7:0];
          dkj_d = M_Rdata_ram[15:8];
          if (skip_c) begin
            skip_now_c = 1'b1;
            adv_c      = 1'b1;
          end else begin
            state_d  = S_RD_IJ;
            launch_c = 1'b1;
          end
        end
      end
      S_RD_IJ: begin
        if (!phase_q) phase_d = 1'b1;
        else if (M_DataRdy[0]) begin
          if (cand_c < M_Rdata_ram[7:0]) begin
            state_d  = S_UPD;
            launch_c = 1'b1;
          end else adv_c = 1'b1;
        end
      end
      S_UPD: begin
        if (!phase_q) phase_d = 1'b1;
        else if (M_DataRdy[0]) adv_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    adv_base_c = skip_now_c ? {iter_q[8:3], 3'd7} : iter_q;
    if (adv_c) begin
      launch_c = 1'b1;
      if (adv_base_c == 9'd511) begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = S_RD_PAIR;
        iter_d  = adv_base_c + 9'd1;
      end
    end

    if (launch_c) begin
      phase_d   = 1'b0;
      m_oe_d    = '0;
      m_we_d    = '0;
      m_addr_d  = '0;
      m_wdata_d = '0;
      m_size_d  = '0;
      case (state_d)
        S_RD_PAIR: begin
          m_oe_d   = 2'b11;
          m_addr_d = {BASE + 12'({iter_d[8:6], iter_d[2:0]}), BASE + 12'({iter_d[5:3], iter_d[8:6]})};
          m_size_d = 8'h88;
        end
        S_RD_IJ: begin
          m_oe_d   = 2'b01;
          m_addr_d = {12'd0, BASE + 12'(iter_d[5:0])};
          m_size_d = 8'h08;
        end
        S_UPD: begin
          m_we_d    = 2'b01;
          m_addr_d  = {12'd0, BASE + 12'(iter_d[5:0])};
          m_wdata_d = {8'd0, cand_c};
          m_size_d  = 8'h08;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned n = 0; n < CELLS; n++) mem_q[6'(n)] <= init_val(n);
      s_rdy_q   <= '0;
      s_rdata_q <= '0;
      state_q   <= S_IDLE;
      phase_q   <= 1'b0;
      iter_q    <= '0;
      dik_q     <= '0;
      dkj_q     <= '0;
      done_q    <= 1'b0;
      m_oe_q    <= '0;
      m_we_q    <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_size_q  <= '0;
    end else begin
      mem_q     <= mem_d;
      s_rdy_q   <= s_rdy_d;
      s_rdata_q <= s_rdata_d;
      state_q   <= state_d;
      phase_q   <= phase_d;
      iter_q    <= iter_d;
      dik_q     <= dik_d;
      dkj_q     <= dkj_d;
      done_q    <= done_d;
      m_oe_q    <= m_oe_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_size_q  <= m_size_d;
    end
  end

  assign done_port          = done_q;
  assign Sout_Rdata_ram     = s_rdata_q;
  assign Sout_DataRdy       = s_rdy_q;
  assign Mout_oe_ram        = m_oe_q;
  assign Mout_we_ram        = m_we_q;
  assign Mout_addr_ram      = m_addr_q;
  assign Mout_Wdata_ram     = m_wdata_q;
  assign Mout_data_ram_size = m_size_q;

endmodule

// File: tb/tb_floyd_warshall_main.sv
// Bench for floyd_warshall_main with the master port looped back onto the slave port (bus OR).
module tb_floyd_warshall_main;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  localparam int BASE = 1024;

  logic        reset = 1'b0, start_port = 1'b0;
  logic [1:0]  tb_oe = '0, tb_we = '0;
  logic [23:0] tb_addr = '0;
  logic [15:0] tb_wdata = '0;
  logic [7:0]  tb_size = '0;

  logic [1:0]  s_oe, s_we, m_rdy, sout_rdy, mout_oe, mout_we;
  logic [23:0] s_addr, mout_addr;
  logic [15:0] s_wdata, m_rdata, sout_rdata, mout_wdata;
  logic [7:0]  s_size, mout_size;
  logic        done_port;

  assign s_oe    = mout_oe | tb_oe;
  assign s_we    = mout_we | tb_we;
  assign s_addr  = mout_addr | tb_addr;
  assign s_wdata = mout_wdata | tb_wdata;
  assign s_size  = mout_size | tb_size;
  assign m_rdata = sout_rdata;
  assign m_rdy   = sout_rdy;

  floyd_warshall_main #(.MEM_var_28859_28864(BASE)) dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(s_oe), .S_we_ram(s_we), .S_addr_ram(s_addr), .S_Wdata_ram(s_wdata),
    .S_data_ram_size(s_size), .M_Rdata_ram(m_rdata), .M_DataRdy(m_rdy),
    .done_port(done_port), .Sout_Rdata_ram(sout_rdata), .Sout_DataRdy(sout_rdy),
    .Mout_oe_ram(mout_oe), .Mout_we_ram(mout_we), .Mout_addr_ram(mout_addr),
    .Mout_Wdata_ram(mout_wdata), .Mout_data_ram_size(mout_size)
  );

  int total = 0, bad = 0;
  int model [64];
  logic [7:0] rd_val [64];
  logic       rd_ok  [64];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic int init_val(input int n);
    int i, j;
    i = n / 8;
    j = n % 8;
    if (i == j) return 0;
    if ((i + j) % 3 == 0) return 255;
    return ((7 * i + 3 * j) % 16) + 1;
  endfunction

  task automatic model_init();
    for (int n = 0; n < 64; n++) model[n] = init_val(n);
  endtask

  task automatic model_blank();
    for (int n = 0; n < 64; n++) model[n] = (n / 8 == n % 8) ? 0 : 255;
  endtask

  // Textbook in-place all-pairs shortest path with saturation at 255.
  task automatic model_fw(output int writes);
    int c;
    writes = 0;
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) begin
          c = model[i*8+k] + model[k*8+j];
          if (c > 255) c = 255;
          if (c < model[i*8+j]) begin
            model[i*8+j] = c;
            writes++;
          end
        end
  endtask

  task automatic wr2(input int a0, input int v0, input int a1, input int v1, input logic [1:0] en);
    tb_we    = en;
    tb_addr  = {12'(a1), 12'(a0)};
    tb_wdata = {8'(v1), 8'(v0)};
    tb_size  = {en[1] ? 4'd8 : 4'd0, en[0] ? 4'd8 : 4'd0};
    tick();
    tb_we = '0; tb_addr = '0; tb_wdata = '0; tb_size = '0;
  endtask

  task automatic rd1(input int ch, input int addr, output logic [7:0] d, output logic rdy);
    tb_oe[ch]            = 1'b1;
    tb_addr[12*ch +: 12] = 12'(addr);
    tb_size[4*ch +: 4]   = 4'd8;
    tick();
    d   = sout_rdata[8*ch +: 8];
    rdy = sout_rdy[ch];
    tb_oe = '0; tb_addr = '0; tb_size = '0;
  endtask

  task automatic load_model();
    for (int n = 0; n < 64; n += 2) wr2(BASE + n, model[n], BASE + n + 1, model[n+1], 2'b11);
  endtask

  task automatic read_all();
    for (int n = 0; n < 64; n++) rd1(n % 2, BASE + n, rd_val[n], rd_ok[n]);
  endtask

  task automatic wait_done(output int cyc, output bit got);
    cyc = 1;
    got = 1'b0;
    while (cyc < 4000) begin
      if (done_port === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
      cyc++;
    end
  endtask

  task automatic run_fw(input bit hold, output int cyc, output bit got);
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    wait_done(cyc, got);
    if (got && hold) start_port = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (done_port !== 1'b0 || mout_oe !== 2'b00 || mout_we !== 2'b00 || mout_addr !== 24'd0 ||
        mout_wdata !== 16'd0 || mout_size !== 8'd0 || sout_rdy !== 2'b00 || sout_rdata !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs done=%0b oe=%0b we=%0b addr=%h rdy=%0b rdata=%h required all zero",
               done_port, mout_oe, mout_we, mout_addr, sout_rdy, sout_rdata);
    end
    model_init();
    read_all();
    for (int n = 0; n < 64; n++) begin
      total++;
      if (rd_ok[n] !== 1'b1 || rd_val[n] !== 8'(model[n])) begin
        bad++;
        $display("FAIL reset_matrix d[%0d][%0d] got=%0d rdy=%0b exp=%0d", n/8, n%8, rd_val[n], rd_ok[n], model[n]);
      end
    end
  endtask

  task automatic test_init_run();
    int w, cyc;
    bit got;
    model_init();
    model_fw(w);
    run_fw(1'b0, cyc, got);
    total++;
    if (!got || cyc != 4*512 + 2*w + 1) begin
      bad++;
      $display("FAIL init_run_latency got_done=%0b cycles=%0d exp=%0d", got, cyc, 4*512 + 2*w + 1);
    end
    tick();
    total++;
    if (done_port !== 1'b0) begin
      bad++;
      $display("FAIL init_run_done_width done=%0b exp=0", done_port);
    end
    read_all();
    total++;
    if (rd_val[1] !== 8'd4 || rd_val[3] !== 8'd5 || rd_val[45] !== 8'd0) begin
      bad++;
      $display("FAIL init_run_known d01=%0d d03=%0d d55=%0d exp 4 5 0", rd_val[1], rd_val[3], rd_val[45]);
    end
    for (int n = 0; n < 64; n++) begin
      total++;
      if (rd_ok[n] !== 1'b1 || rd_val[n] !== 8'(model[n])) begin
        bad++;
        $display("FAIL init_run_matrix d[%0d][%0d] got=%0d rdy=%0b exp=%0d", n/8, n%8, rd_val[n], rd_ok[n], model[n]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int w1, w2, c1, c2;
    bit g1, g2;
    model_fw(w1);
    model_fw(w2);
    run_fw(1'b1, c1, g1);
    tick();
    start_port = 1'b0;
    total++;
    if (!g1 || c1 != 4*512 + 2*w1 + 1) begin
      bad++;
      $display("FAIL b2b_first got_done=%0b cycles=%0d exp=%0d", g1, c1, 4*512 + 2*w1 + 1);
    end
    total++;
    if (done_port !== 1'b0 || mout_oe !== 2'b11) begin
      bad++;
      $display("FAIL b2b_restart done=%0b oe=%0b exp done=0 oe=11", done_port, mout_oe);
    end
    wait_done(c2, g2);
    total++;
    if (!g2 || c2 != 4*512 + 2*w2 + 1) begin
      bad++;
      $display("FAIL b2b_second got_done=%0b cycles=%0d exp=%0d", g2, c2, 4*512 + 2*w2 + 1);
    end
    tick();
  endtask

  task automatic test_slave_rw();
    logic [7:0] d;
    logic r;
    int old;
    wr2(1033, 8'h05, 0, 0, 2'b01);
    total++;
    if (sout_rdy !== 2'b01) begin
      bad++;
      $display("FAIL slave_write_ack rdy=%0b exp=01", sout_rdy);
    end
    model[9] = 5;
    rd1(1, 1033, d, r);
    total++;
    if (r !== 1'b1 || d !== 8'h05) begin
      bad++;
      $display("FAIL slave_readback rdy=%0b data=%h exp rdy=1 data=05", r, d);
    end
    old = model[10];
    tb_we = 2'b01; tb_oe = 2'b10; tb_addr = {12'(BASE+10), 12'(BASE+10)}; tb_wdata = 16'h0066;
    tick();
    tb_we = '0; tb_oe = '0; tb_addr = '0; tb_wdata = '0;
    total++;
    if (sout_rdy !== 2'b11 || sout_rdata[15:8] !== 8'(old)) begin
      bad++;
      $display("FAIL slave_rd_old rdy=%0b data=%h exp rdy=11 data=%h", sout_rdy, sout_rdata[15:8], 8'(old));
    end
    model[10] = 8'h66;
    wr2(BASE+11, 8'h11, BASE+11, 8'h22, 2'b11);
    model[11] = 8'h22;
    old = model[12];
    tb_oe = 2'b01; tb_we = 2'b01; tb_addr = {12'd0, 12'(BASE+12)}; tb_wdata = 16'h0099;
    tick();
    tb_we = '0; tb_oe = '0; tb_addr = '0; tb_wdata = '0;
    total++;
    if (sout_rdy[0] !== 1'b1 || sout_rdata[7:0] !== 8'(old)) begin
      bad++;
      $display("FAIL slave_oe_we_read rdy=%0b data=%h exp rdy=1 data=%h", sout_rdy[0], sout_rdata[7:0], 8'(old));
    end
    for (int n = 10; n < 13; n++) begin
      rd1(0, BASE + n, d, r);
      total++;
      if (r !== 1'b1 || d !== 8'(model[n])) begin
        bad++;
        $display("FAIL slave_contents addr=%0d got=%h exp=%h", BASE + n, d, 8'(model[n]));
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [7:0] d;
    logic r;
    int addrs [2];
    addrs[0] = 1088;
    addrs[1] = 1023;
    for (int t = 0; t < 2; t++) begin
      rd1(t, addrs[t], d, r);
      for (int c = 0; c < 3; c++) begin
        total++;
        if (sout_rdy !== 2'b00 || sout_rdata !== 16'd0) begin
          bad++;
          $display("FAIL out_of_range addr=%0d cyc=%0d rdy=%0b data=%h exp 0", addrs[t], c, sout_rdy, sout_rdata);
        end
        tick();
      end
    end
  endtask

  task automatic run_and_check(input string tag);
    int w, cyc;
    bit got;
    load_model();
    model_fw(w);
    run_fw(1'b0, cyc, got);
    total++;
    if (!got || cyc != 4*512 + 2*w + 1) begin
      bad++;
      $display("FAIL %s_latency got_done=%0b cycles=%0d exp=%0d", tag, got, cyc, 4*512 + 2*w + 1);
    end
    tick();
    read_all();
  endtask

  task automatic test_chain();
    model_blank();
    model[1] = 3;
    model[10] = 4;
    run_and_check("chain");
    total++;
    if (rd_val[2] !== 8'd7 || rd_val[16] !== 8'd255 || rd_val[8] !== 8'd255) begin
      bad++;
      $display("FAIL chain_known d02=%0d d20=%0d d10=%0d exp 7 255 255", rd_val[2], rd_val[16], rd_val[8]);
    end
    for (int n = 0; n < 64; n++) begin
      total++;
      if (rd_ok[n] !== 1'b1 || rd_val[n] !== 8'(model[n])) begin
        bad++;
        $display("FAIL chain_matrix d[%0d][%0d] got=%0d exp=%0d", n/8, n%8, rd_val[n], model[n]);
      end
    end
  endtask

  task automatic test_saturation();
    model_blank();
    model[1] = 200;
    model[10] = 100;
    run_and_check("sat");
    total++;
    if (rd_val[2] !== 8'd255 || rd_val[1] !== 8'd200 || rd_val[10] !== 8'd100) begin
      bad++;
      $display("FAIL saturation d02=%0d d01=%0d d12=%0d exp 255 200 100", rd_val[2], rd_val[1], rd_val[10]);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      for (int n = 0; n < 64; n++)
        if (n / 8 == n % 8) model[n] = 0;
        else model[n] = ($urandom_range(0, 9) < 4) ? 255 : int'($urandom_range(1, 60 + 60*r));
      run_and_check("random");
      for (int n = 0; n < 64; n++) begin
        total++;
        if (rd_ok[n] !== 1'b1 || rd_val[n] !== 8'(model[n])) begin
          bad++;
          $display("FAIL random%0d_matrix d[%0d][%0d] got=%0d exp=%0d", r, n/8, n%8, rd_val[n], model[n]);
        end
      end
    end
  endtask

  task automatic test_reset_midrun();
    logic [7:0] d;
    logic r;
    int seen;
    do_reset();
    wr2(BASE + 1, 77, 0, 0, 2'b01);
    start_port = 1'b1;
    tick();
    start_port = 1'b0;
    repeat (100) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    total++;
    if (mout_oe !== 2'b00 || mout_we !== 2'b00 || done_port !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset_outputs oe=%0b we=%0b done=%0b exp 0", mout_oe, mout_we, done_port);
    end
    seen = 0;
    repeat (2500) begin
      tick();
      if (done_port === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++;
      $display("FAIL midrun_no_done pulses=%0d exp=0", seen);
    end
    rd1(0, BASE + 1, d, r);
    total++;
    if (r !== 1'b1 || d !== 8'd4) begin
      bad++;
      $display("FAIL midrun_reload d01=%0d rdy=%0b exp=4", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_init_run();
    test_back_to_back();
    test_slave_rw();
    test_out_of_range();
    test_chain();
    test_saturation();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
